// File: rtl/tile_map_arbiter_pkg.sv
// Shared constants, tile codes and FSM encoding for the tile map arbiter.
package tile_map_arbiter_pkg;

  localparam int unsigned BOARD_W      = 20;
  localparam int unsigned BOARD_H      = 10;
  localparam int unsigned NUM_TILES    = BOARD_W * BOARD_H;
  localparam int unsigned ADDR_W       = 8;
  localparam int unsigned CODE_W       = 4;
  localparam int unsigned STARVE_LIMIT = 16;

  localparam logic [CODE_W-1:0] CODE_SHIP   = 4'd0;
  localparam logic [CODE_W-1:0] CODE_HIT    = 4'd1;
  localparam logic [CODE_W-1:0] CODE_MISS   = 4'd2;
  localparam logic [CODE_W-1:0] CODE_CURSOR = 4'd3;
  localparam logic [CODE_W-1:0] CODE_EMPTY  = 4'd4;
  localparam logic [CODE_W-1:0] EMPTY_CODE  = CODE_EMPTY;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tile_map_arbiter_starve_counter.sv
// Counts consecutive denied cycles; flags when the limit is reached.
module starve_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic tc_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_W'(LIMIT))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_c = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/tile_map_arbiter.sv
// Tile map RAM port arbiter: video reads first, game writes and board clear
// behind them, with a starvation guard that forces the FSM owner through.
module tile_map_arbiter
  import tile_map_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_rd_en,
  input  logic [ADDR_W-1:0] vid_tile_addr,
  output logic [CODE_W-1:0] vid_tile_data,
  output logic              vid_tile_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CODE_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [CODE_W-1:0] ram_wdata,
  input  logic [CODE_W-1:0] ram_rdata
);

  arb_state_e        st;
  logic [ADDR_W-1:0] clr_ptr;
  logic [CODE_W-1:0] hold_q;
  logic              tc_c;
  logic              force_c;
  logic              vid_grant_c;
  logic              fsm_grant_c;
  logic              wr_in_range_c;

  assign force_c       = tc_c && (st != IDLE);
  assign vid_grant_c   = vid_rd_en && !force_c;
  // A reset cycle never lets the FSM touch the RAM, so a clear stops dead.
  assign fsm_grant_c   = (st != IDLE) && !vid_grant_c && !rst;
  assign wr_in_range_c = (wr_addr < ADDR_W'(NUM_TILES));

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk  (clk),
    .rst  (rst),
    .inc  ((st != IDLE) && vid_grant_c),
    .clr  (fsm_grant_c),
    .tc_c (tc_c)
  );

  // RAM port mux driven straight from the grant decision.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (vid_grant_c) begin
      ram_addr = vid_tile_addr;
    end else if (fsm_grant_c) begin
      case (st)
        WRITE: begin
          ram_addr  = wr_addr;
          ram_wdata = wr_data;
          ram_we    = wr_in_range_c;
        end
        CLEAR: begin
          ram_addr  = clr_ptr;
          ram_wdata = EMPTY_CODE;
          ram_we    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= IDLE;
      clr_ptr        <= '0;
      busy           <= 1'b0;
      wr_ack         <= 1'b0;
      vid_tile_valid <= 1'b0;
      hold_q         <= '0;
    end else begin
      vid_tile_valid <= vid_grant_c;
      wr_ack         <= 1'b0;
      if (vid_tile_valid) begin
        hold_q <= ram_rdata;
      end
      case (st)
        IDLE: begin
          if (clr_req) begin
            st      <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
          end else if (wr_req) begin
            st <= WRITE;
          end
        end
        WRITE: begin
          if (fsm_grant_c) begin
            wr_ack <= 1'b1;
            st     <= IDLE;
          end
        end
        CLEAR: begin
          if (fsm_grant_c) begin
            if (clr_ptr == ADDR_W'(NUM_TILES - 1)) begin
              st   <= IDLE;
              busy <= 1'b0;
            end else begin
              clr_ptr <= clr_ptr + ADDR_W'(1);
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign vid_tile_data = vid_tile_valid ? ram_rdata : hold_q;

endmodule

// File: doc/tile_map_arbiter.md
Name: tile_map_arbiter

Overview:
- Shares the single-port, synchronous-read tile map RAM between two requesters: the video painter, which fetches tile codes, and game logic, which writes tile codes.
- Also sequences a whole-board clear that fills every tile with the EMPTY code.
- Sits between the paint-screen datapath and the tile RAM instance.
- Video reads have priority; a starvation guard ensures game writes always complete.

Parameters:
- NUM_TILES, 200, tile entries in the map (20x10 board); legal addresses 0..NUM_TILES-1.
- ADDR_W, 8, tile address width.
- CODE_W, 4, tile code width.
- EMPTY_CODE, 4'd4, code written by a clear.
- STARVE_LIMIT, 16, consecutive denied cycles before a pending write or clear step is forced.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- vid_rd_en  in  1  painter requests a read this cycle
- vid_tile_addr  in  ADDR_W  painter read address
- vid_tile_data  out  CODE_W  read data, one cycle after the request
- vid_tile_valid  out  1  vid_tile_data is valid this cycle
- wr_req  in  1  game write request; held high until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  CODE_W  write code
- wr_ack  out  1  one-cycle pulse; the write was issued this cycle
- clr_req  in  1  pulse; start a board clear
- busy  out  1  clear in progress
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  CODE_W  RAM write data
- ram_rdata  in  CODE_W  RAM read data (1-cycle latency)

Behaviour:
- Reset values:
  - vid_tile_valid=0, vid_tile_data=0, wr_ack=0, busy=0.
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - FSM in IDLE, starve counter 0, clear pointer 0.
- RAM port outputs are combinational from the grant decision. vid_tile_valid and wr_ack are registered.
- Grant per cycle:
  - Video is granted when vid_rd_en=1 and no force is active.
  - Otherwise the FSM owner gets the port.
  - Exactly one owner per cycle. ram_we=0 whenever video is granted.
- FSM states:
  - IDLE:
    - clr_req=1 -> CLEAR, clear pointer=0, busy=1. clr_req has priority over a simultaneous wr_req.
    - Else wr_req=1 -> WRITE.
  - WRITE:
    - When granted: ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data.
    - wr_ack pulses the next cycle; return to IDLE.
    - wr_req must drop after wr_ack; a still-high wr_req in IDLE is treated as a new request.
  - CLEAR:
    - Each granted cycle: ram_we=1, ram_addr=pointer, ram_wdata=EMPTY_CODE, pointer+1.
    - After writing NUM_TILES-1 -> IDLE, busy=0 on the next cycle.
    - wr_req is not acked during CLEAR. clr_req during CLEAR is ignored.
- Video read:
  - vid_tile_valid is a one-cycle-delayed copy of the video grant.
  - vid_tile_data = ram_rdata when valid, else holds its last value.
  - A denied vid_rd_en gives vid_tile_valid=0 next cycle; the painter holds its previous tile color.
- Starvation guard:
  - Counter increments each cycle the FSM is in WRITE or CLEAR and loses to video.
  - It resets to 0 on any FSM-owned RAM cycle.
  - When the counter reaches STARVE_LIMIT, the next cycle is forced to the FSM regardless of vid_rd_en, and the counter clears.
- Boundaries:
  - wr_addr >= NUM_TILES: acked, no write issued (ram_we=0).
  - vid_tile_addr is passed through unchecked.
  - Clear pointer never wraps past NUM_TILES-1.
  - rst mid-clear or mid-write: immediate return to IDLE, no ack, busy=0; a partially cleared RAM is left as is.

Decomposition:
- Shared package/header holds:
  - tile code constants: SHIP=0, HIT=1, MISS=2, CURSOR=3, EMPTY=4;
  - NUM_TILES and board dimensions;
  - FSM state encodings IDLE=2'd0, WRITE=2'd1, CLEAR=2'd2.
- One natural sub-module, starve_counter: counter with increment, clear and terminal-count flag, parameterised on STARVE_LIMIT. Everything else stays inline.

Test Plan:
- Reset then idle, vid_rd_en=1 at addr 5 with RAM[5]=3 -> next cycle vid_tile_valid=1, vid_tile_data=3; ram_we never 1.
- vid_rd_en=0, wr_req with addr 10, data 1 -> ram_we=1 at addr 10 the same cycle the request is seen in WRITE; wr_ack one cycle later; a later read of 10 returns 1.
- vid_rd_en held 1 continuously, wr_req addr 7 data 2 -> write is forced after exactly 16 denied cycles; that cycle's read returns valid=0; wr_ack follows.
- clr_req with vid_rd_en toggling 50% -> all 200 addresses read back 4; busy high from the cycle after clr_req until the cycle after address 199 is written; a wr_req during the clear is acked only after busy=0.
- clr_req and wr_req in the same cycle -> clear runs first; the write lands afterward and survives (read returns wr_data).
- rst asserted mid-clear at pointer 80 -> busy=0 next cycle, no wr_ack; addresses 0..79 are EMPTY and 80+ are unchanged.
